// File: rtl/counter_read_ctrl_pkg.sv
// Shared timer definitions: register offsets, read FSM states and status bits.
// The offsets are also used by the write-path decoder, so keep them here.
package counter_read_ctrl_pkg;

  localparam logic [11:0] TDR0_OFFSET  = 12'h004;
  localparam logic [11:0] TDR1_OFFSET  = 12'h008;
  localparam logic [11:0] TSTAT_OFFSET = 12'h00C;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP
  } rd_state_e;

  localparam int TSTAT_CNT_EN_BIT     = 0;
  localparam int TSTAT_SNAP_VALID_BIT = 1;

  // Build the status word from its two live bits; all other bits read as zero.
  function automatic logic [31:0] tstat_word(input logic snap_valid, input logic cnt_en);
    logic [31:0] w;
    w = '0;
    w[TSTAT_SNAP_VALID_BIT] = snap_valid;
    w[TSTAT_CNT_EN_BIT]     = cnt_en;
    return w;
  endfunction

endpackage

// File: rtl/counter_read_ctrl_if.sv
// APB-style read bus between the fabric (master) and the counter read block (slave).
interface counter_read_ctrl_if #(
  parameter int ADDR_W = 12
);
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic              pready;
  logic [31:0]       prdata;
  logic              pslverr;

  modport master (
    output psel, penable, pwrite, paddr,
    input  pready, prdata, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr,
    output pready, prdata, pslverr
  );
endinterface

// File: rtl/counter_read_ctrl_snapshot.sv
// Shadow of the counter high word taken when the low word is read, so a
// following high-word read is coherent with it even while the counter runs.
module counter_read_ctrl_snapshot (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        capture,
  input  logic [31:0] capture_hi,
  input  logic        consume,
  input  logic        clear,
  output logic [31:0] shadow_hi,
  output logic        snap_valid
);

  // Capture beats clear beats consume: a low-word read landing on a counter
  // clear still leaves a valid snapshot of the value it returned.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      shadow_hi  <= '0;
      snap_valid <= 1'b0;
    end else if (capture) begin
      shadow_hi  <= capture_hi;
      snap_valid <= 1'b1;
    end else if (clear) begin
      shadow_hi  <= '0;
      snap_valid <= 1'b0;
    end else if (consume) begin
      snap_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/counter_read_ctrl.sv
// Read-side register block for the 64-bit timer counter. Returns the counter
// in two 32-bit halves with a shadowed high word for coherent 64-bit reads.
module counter_read_ctrl
  import counter_read_ctrl_pkg::*;
#(
  parameter int                ADDR_W      = 12,
  parameter logic [ADDR_W-1:0] TDR0_ADDR   = ADDR_W'(TDR0_OFFSET),
  parameter logic [ADDR_W-1:0] TDR1_ADDR   = ADDR_W'(TDR1_OFFSET),
  parameter logic [ADDR_W-1:0] TSTAT_ADDR  = ADDR_W'(TSTAT_OFFSET),
  parameter int                WAIT_STATES = 1
) (
  input  logic                sys_clk,
  input  logic                sys_rst_n,
  counter_read_ctrl_if.slave  bus,
  input  logic [63:0]         cnt_val,
  input  logic                cnt_en,
  input  logic                counter_clear
);

  rd_state_e         state;
  logic [1:0]        wait_cnt;
  logic [ADDR_W-1:0] cap_addr;
  logic              cap_write;
  logic              cap_en;
  logic [63:0]       cap_cnt;
  logic [31:0]       shadow_hi;
  logic              snap_valid;
  logic              resp_go;
  logic              snap_capture;
  logic              snap_consume;
  logic [31:0]       rd_data;
  logic              rd_err;

  // The transfer commits on the edge that moves ACCESS into RESP.
  assign resp_go      = (state == ACCESS) && bus.psel && (wait_cnt == 2'd0);
  assign snap_capture = resp_go && !cap_write && (cap_addr == TDR0_ADDR);
  assign snap_consume = resp_go && !cap_write && (cap_addr == TDR1_ADDR);

  // Read data and error decode from the values captured at the start of ACCESS.
  always_comb begin
    rd_data = '0;
    rd_err  = 1'b0;
    if (!cap_write) begin
      if (cap_addr == TDR0_ADDR) begin
        rd_data = cap_cnt[31:0];
      end else if (cap_addr == TDR1_ADDR) begin
        rd_data = snap_valid ? shadow_hi : cap_cnt[63:32];
      end else if (cap_addr == TSTAT_ADDR) begin
        rd_data = tstat_word(snap_valid, cap_en);
      end else begin
        rd_err = 1'b1;
      end
    end
  end

  // Capture registers: hold the request and counter value seen on the first
  // ACCESS edge; pure data, so no reset.
  always_ff @(posedge sys_clk) begin
    if ((state == SETUP) && bus.psel && bus.penable) begin
      cap_addr  <= bus.paddr;
      cap_write <= bus.pwrite;
      cap_cnt   <= cnt_val;
      cap_en    <= cnt_en;
    end
  end

  // Bus FSM with registered pready/prdata/pslverr; dropping psel aborts.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state       <= IDLE;
      wait_cnt    <= 2'd0;
      bus.pready  <= 1'b0;
      bus.prdata  <= '0;
      bus.pslverr <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.psel && !bus.penable) state <= SETUP;
        end
        SETUP: begin
          if (!bus.psel) begin
            state <= IDLE;
          end else if (bus.penable) begin
            state    <= ACCESS;
            wait_cnt <= 2'(WAIT_STATES);
          end
        end
        ACCESS: begin
          if (!bus.psel) begin
            state <= IDLE;
          end else if (wait_cnt != 2'd0) begin
            wait_cnt <= wait_cnt - 2'd1;
          end else begin
            state       <= RESP;
            bus.pready  <= 1'b1;
            bus.prdata  <= rd_data;
            bus.pslverr <= rd_err;
          end
        end
        RESP: begin
          state       <= IDLE;
          bus.pready  <= 1'b0;
          bus.prdata  <= '0;
          bus.pslverr <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  counter_read_ctrl_snapshot u_counter_snapshot (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .capture    (snap_capture),
    .capture_hi (cap_cnt[63:32]),
    .consume    (snap_consume),
    .clear      (counter_clear),
    .shadow_hi  (shadow_hi),
    .snap_valid (snap_valid)
  );

endmodule

// File: tb/tb_counter_read_ctrl.sv
// Directed bench for counter_read_ctrl: three instances with 0, 1 and 3 wait
// states share one bus drive; instance 1 carries the functional reads.
module tb_counter_read_ctrl;

  localparam logic [11:0] A_TDR0  = 12'h004;
  localparam logic [11:0] A_TDR1  = 12'h008;
  localparam logic [11:0] A_TSTAT = 12'h00C;
  localparam logic [11:0] A_BAD   = 12'h010;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        psel, penable, pwrite;
  logic [11:0] paddr;
  logic [63:0] cnt_val;
  logic        cnt_en, counter_clear, cnt_run;

  int n_cmp = 0;
  int n_bad = 0;
  int rise[4];
  int hi[4];
  int idle_bad = 0;

  logic [31:0] rd;
  logic        er;

  always #5 clk = ~clk;

  counter_read_ctrl_if #(.ADDR_W(12)) bus0 ();
  counter_read_ctrl_if #(.ADDR_W(12)) bus1 ();
  counter_read_ctrl_if #(.ADDR_W(12)) bus3 ();

  assign bus0.psel = psel;  assign bus0.penable = penable;
  assign bus0.pwrite = pwrite;  assign bus0.paddr = paddr;
  assign bus1.psel = psel;  assign bus1.penable = penable;
  assign bus1.pwrite = pwrite;  assign bus1.paddr = paddr;
  assign bus3.psel = psel;  assign bus3.penable = penable;
  assign bus3.pwrite = pwrite;  assign bus3.paddr = paddr;

  counter_read_ctrl #(.WAIT_STATES(0)) dut0 (
    .sys_clk(clk), .sys_rst_n(rst_n), .bus(bus0.slave),
    .cnt_val(cnt_val), .cnt_en(cnt_en), .counter_clear(counter_clear));
  counter_read_ctrl #(.WAIT_STATES(1)) dut1 (
    .sys_clk(clk), .sys_rst_n(rst_n), .bus(bus1.slave),
    .cnt_val(cnt_val), .cnt_en(cnt_en), .counter_clear(counter_clear));
  counter_read_ctrl #(.WAIT_STATES(3)) dut3 (
    .sys_clk(clk), .sys_rst_n(rst_n), .bus(bus3.slave),
    .cnt_val(cnt_val), .cnt_en(cnt_en), .counter_clear(counter_clear));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One cycle: advance to the next falling edge; the modelled counter runs here.
  task automatic tick();
    @(negedge clk);
    if (cnt_run) cnt_val = cnt_val + 64'd1;
  endtask

  function automatic logic pready_of(input int s);
    case (s)
      0: return bus0.pready;
      1: return bus1.pready;
      default: return bus3.pready;
    endcase
  endfunction

  // Track pready rise/width per instance and flag nonzero outputs while idle.
  task automatic sample(input int n);
    if (bus0.pready) begin hi[0]++; if (rise[0] == 0) rise[0] = n; end
    else if (bus0.prdata != 32'd0 || bus0.pslverr) idle_bad++;
    if (bus1.pready) begin hi[1]++; if (rise[1] == 0) rise[1] = n; end
    else if (bus1.prdata != 32'd0 || bus1.pslverr) idle_bad++;
    if (bus3.pready) begin hi[3]++; if (rise[3] == 0) rise[3] = n; end
    else if (bus3.prdata != 32'd0 || bus3.pslverr) idle_bad++;
  endtask

  // Full transfer ended by the target instance's pready; called at a falling edge.
  task automatic apb(input int tgt, input logic wr, input logic [11:0] addr,
                     output logic [31:0] data, output logic err);
    logic got;
    got = 1'b0; data = '0; err = 1'b0;
    for (int i = 0; i < 4; i++) begin rise[i] = 0; hi[i] = 0; end
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr;
    tick();
    penable = 1'b1;
    for (int n = 1; n <= 20 && !got; n++) begin
      tick();
      sample(n);
      if (pready_of(tgt)) begin
        got  = 1'b1;
        data = (tgt == 0) ? bus0.prdata : (tgt == 1) ? bus1.prdata : bus3.prdata;
        err  = (tgt == 0) ? bus0.pslverr : (tgt == 1) ? bus1.pslverr : bus3.pslverr;
      end
    end
    if (!got) chk($sformatf("timeout addr %0h", addr), 64'(got), 64'd1);
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    tick();
    sample(99);
    chk($sformatf("pready width addr %0h", addr), 64'(pready_of(tgt)), 64'd0);
  endtask

  initial begin
    int cnt;
    rst_n = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0;
    cnt_val = '0; cnt_en = 1'b0; counter_clear = 1'b0; cnt_run = 1'b0;
    tick(); tick();
    chk("reset pready", 64'(bus1.pready), 64'd0);
    chk("reset prdata", 64'(bus1.prdata), 64'd0);
    chk("reset pslverr", 64'(bus1.pslverr), 64'd0);
    rst_n = 1'b1;
    tick();
    apb(1, 1'b0, A_TSTAT, rd, er);
    chk("tstat after reset", 64'(rd), 64'h0);

    // Coherent 64-bit read across a high-word carry.
    cnt_en = 1'b1; cnt_val = 64'h0000_0001_FFFF_FFFD; cnt_run = 1'b1;
    apb(1, 1'b0, A_TDR0, rd, er);
    chk("coherent tdr0", 64'(rd), 64'hFFFF_FFFE);
    apb(1, 1'b0, A_TSTAT, rd, er);
    chk("tstat snap valid", 64'(rd), 64'h3);
    apb(1, 1'b0, A_TDR1, rd, er);
    chk("coherent tdr1", 64'(rd), 64'h0000_0001);
    chk("live high moved on", 64'(cnt_val[63:32]), 64'h2);
    apb(1, 1'b0, A_TSTAT, rd, er);
    chk("tstat after tdr1", 64'(rd), 64'h1);
    cnt_run = 1'b0;

    // High word without a snapshot reads live.
    cnt_val = 64'hABCD_0123_5555_AAAA;
    apb(1, 1'b0, A_TDR1, rd, er);
    chk("direct tdr1", 64'(rd), 64'hABCD_0123);

    // Counter clear invalidates the snapshot.
    cnt_val = 64'h1234_5678_9ABC_DEF0;
    apb(1, 1'b0, A_TDR0, rd, er);
    chk("clear tdr0", 64'(rd), 64'h9ABC_DEF0);
    counter_clear = 1'b1; cnt_val = '0;
    tick();
    counter_clear = 1'b0;
    apb(1, 1'b0, A_TSTAT, rd, er);
    chk("tstat after clear", 64'(rd), 64'h1);
    apb(1, 1'b0, A_TDR1, rd, er);
    chk("tdr1 after clear", 64'(rd), 64'h0);

    // Unmapped read and write transfer.
    apb(1, 1'b0, A_BAD, rd, er);
    chk("unmapped prdata", 64'(rd), 64'h0);
    chk("unmapped pslverr", 64'(er), 64'h1);
    cnt_val = 64'h0000_00AA_0000_0055;
    apb(1, 1'b0, A_TDR0, rd, er);
    chk("pre-write tdr0", 64'(rd), 64'h55);
    apb(1, 1'b1, A_TDR0, rd, er);
    chk("write prdata", 64'(rd), 64'h0);
    chk("write pslverr", 64'(er), 64'h0);
    apb(1, 1'b0, A_TSTAT, rd, er);
    chk("tstat after write", 64'(rd), 64'h3);
    cnt_val = 64'h0000_00BB_0000_0066;
    apb(1, 1'b0, A_TDR1, rd, er);
    chk("tdr1 after write", 64'(rd), 64'hAA);

    // Latency of all three instances on one transfer.
    apb(3, 1'b0, A_TSTAT, rd, er);
    chk("latency ws0", 64'(rise[0]), 64'd2);
    chk("latency ws1", 64'(rise[1]), 64'd3);
    chk("latency ws3", 64'(rise[3]), 64'd5);
    chk("width ws0", 64'(hi[0]), 64'd1);
    chk("width ws1", 64'(hi[1]), 64'd1);
    chk("width ws3", 64'(hi[3]), 64'd1);
    chk("ws3 tstat", 64'(rd), 64'h1);

    // Abort during ACCESS leaves the snapshot alone.
    cnt_val = 64'h0000_0CCC_0000_0DDD;
    apb(1, 1'b0, A_TDR0, rd, er);
    chk("abort pre tdr0", 64'(rd), 64'hDDD);
    cnt_val = 64'h0000_0EEE_0000_0DDD;
    psel = 1'b1; penable = 1'b0; paddr = A_TDR1; pwrite = 1'b0;
    tick();
    penable = 1'b1;
    tick();
    psel = 1'b0; penable = 1'b0;
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus1.pready || bus0.pready || bus3.pready) cnt++;
    end
    chk("abort pready", 64'(cnt), 64'd0);
    apb(1, 1'b0, A_TSTAT, rd, er);
    chk("abort tstat", 64'(rd), 64'h3);
    apb(1, 1'b0, A_TDR1, rd, er);
    chk("abort tdr1 shadow", 64'(rd), 64'hCCC);

    // Reset while instance 0 is in RESP and instance 1 is still in ACCESS.
    cnt_val = 64'h0000_0777_0000_0888;
    apb(1, 1'b0, A_TDR0, rd, er);
    chk("reset pre tdr0", 64'(rd), 64'h888);
    psel = 1'b1; penable = 1'b0; paddr = A_TDR0; pwrite = 1'b0;
    tick();
    penable = 1'b1;
    tick();
    tick();
    chk("ws0 resp before reset", 64'(bus0.pready), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("async reset pready", 64'(bus0.pready), 64'd0);
    chk("async reset prdata", 64'(bus0.prdata), 64'd0);
    chk("reset ws1 pready", 64'(bus1.pready), 64'd0);
    psel = 1'b0; penable = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    cnt_en = 1'b0;
    apb(1, 1'b0, A_TSTAT, rd, er);
    chk("tstat after mid reset", 64'(rd), 64'h0);
    cnt_val = 64'h0000_0000_1357_2468;
    apb(1, 1'b0, A_TDR0, rd, er);
    chk("read after reset", 64'(rd), 64'h1357_2468);

    chk("outputs zero while idle", 64'(idle_bad), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/counter_read_ctrl.md
Name: counter_read_ctrl

Overview:
- APB-style read-side register interface for the 64-bit timer counter; complements the existing write path, which loads the counter in 32-bit halves.
- Gives a 32-bit bus master coherent 64-bit reads. Reading the low word snapshots the high word into a shadow register, so a following high-word read returns the matching half even while the counter runs.
- Sits between the bus fabric and the counter's cnt_val output; read-only and never modifies the counter.

Parameters:
- ADDR_W, 12, width of paddr
- TDR0_ADDR, 12'h004, address of counter low word
- TDR1_ADDR, 12'h008, address of counter high word
- TSTAT_ADDR, 12'h00C, address of read status word
- WAIT_STATES, 1, extra ACCESS cycles before pready; legal range 0..3

Ports:
- sys_clk  in  1  system clock
- sys_rst_n  in  1  reset, asynchronous, active-low
- psel  in  1  bus select
- penable  in  1  bus access phase
- pwrite  in  1  1 = write transfer (ignored here), 0 = read
- paddr  in  ADDR_W  transfer address
- pready  out  1  transfer completion, registered
- prdata  out  32  read data, valid only while pready=1
- pslverr  out  1  error response, valid only while pready=1
- cnt_val  in  64  live counter value
- cnt_en  in  1  counter enable, reported in status
- counter_clear  in  1  counter clear strobe; invalidates the snapshot

Behaviour:
- Reset values: pready=0, prdata=0, pslverr=0, shadow_hi=0, snap_valid=0, wait_cnt=0; FSM in IDLE.
- FSM states:
  - IDLE: psel=1 and penable=0 -> SETUP.
  - SETUP: psel=1 and penable=1 -> ACCESS. On this first ACCESS edge, latch paddr, pwrite, cnt_val and cnt_en into the capture registers; load wait_cnt=WAIT_STATES.
  - ACCESS: if wait_cnt>0, decrement. At wait_cnt==0 -> RESP, driving the registered outputs.
  - RESP: pready=1 for exactly one cycle, then -> IDLE, with prdata/pslverr returning to 0.
- Latency: pready rises 2+WAIT_STATES cycles after the first cycle with psel=1 and penable=1. With WAIT_STATES=0, that is the second cycle after it.
- Back-to-back transfers: a new SETUP may begin in the cycle after RESP. No pipelining.
- Read TDR0: prdata = captured cnt_val[31:0]; shadow_hi <= captured cnt_val[63:32]; snap_valid <= 1. Both update on the RESP edge.
- Read TDR1:
  - snap_valid=1: prdata = shadow_hi, then snap_valid <= 0.
  - snap_valid=0: prdata = captured cnt_val[63:32].
- Read TSTAT: prdata = {30'b0, snap_valid, captured cnt_en}. No side effects.
- Unmapped read: prdata=0, pslverr=1. No side effects.
- Write transfer (pwrite=1), any address: completes with normal timing, prdata=0, pslverr=0. No state change; the write path lives elsewhere.
- counter_clear=1 in any cycle: snap_valid <= 0, shadow_hi <= 0.
  - If this coincides with a TDR0 RESP edge, the TDR0 update wins: snapshot taken from the captured value, snap_valid=1.
  - A TDR1 read completing in the same cycle still returns shadow_hi as it was before the clear.
- Abort: if psel drops before RESP, the FSM returns to IDLE next cycle. pready is never asserted and the snapshot is not touched.
- Counter wrap (all ones -> 0) needs no special handling; the snapshot stays coherent.
- Reset mid-transfer: immediate return to reset values; the transfer is never completed.

Decomposition:
- Shared timer package holds:
  - register offset constants TDR0/TDR1/TSTAT, also used by the write-path decoder
  - FSM state enum {IDLE, SETUP, ACCESS, RESP}
  - status bit positions
- One natural sub-module, counter_snapshot: holds shadow_hi and snap_valid, with capture, consume and clear inputs. The FSM and bus decode stay in the top module.

Test Plan:
- Coherent read: cnt_val=64'h0000_0001_FFFF_FFFE counting, WAIT_STATES=1. Read TDR0 -> 32'hFFFF_FFFE; later read TDR1 -> 32'h0000_0001, even though the live high word is now 2. TSTAT bit1 is 0 after the TDR1 read.
- Direct high read: TDR1 read with no snapshot, cnt_val[63:32]=32'hABCD_0123 -> prdata=32'hABCD_0123.
- Clear invalidation: TDR0 read, then counter_clear pulse, then TDR1 read with live high=0 -> prdata=0; TSTAT bit1=0 after the clear.
- Latency/handshake: WAIT_STATES=0 and 3 -> pready rises exactly 2 and 5 cycles after the first penable cycle, high one cycle; prdata=0 whenever pready=0.
- Error and write: read 12'h010 -> pslverr=1, prdata=0. Write to TDR0 -> pslverr=0, snapshot unchanged.
- Abort/reset: drop psel during ACCESS -> no pready, snap_valid unchanged. Assert sys_rst_n=0 mid-ACCESS -> all outputs 0 immediately; the next read completes normally.
